// File: rtl/hazard_unit_fwd.sv
// hazard_unit_fwd: decode-side hazard detection, forwarding select and control-transfer penalty
// Ports:
//   clk, rst (async, active-low)
//   id_*      : decode-stage instruction (sources, destination, load/store/cti, memory address)
//   pc_stall  : hold PC and IF/ID
//   bubble    : turn the ID/EX payload into a NOP
//   fwd_rs/rt : 0 = register file, k+1 = result of shadow entry k
module hazard_unit_fwd #(
    parameter int REG_AW     = 3,
    parameter int PIPE_DEPTH = 4,
    parameter int FWD_EN     = 1,
    parameter int R0_ZERO    = 0,
    parameter int BR_PENALTY = 1,
    parameter int MEM_CHECK  = 1,
    parameter int MEM_AW     = 16,
    localparam int FW        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rs_use,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_use,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_wr,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic [MEM_AW-1:0] id_mem_addr,
    input  logic              id_cti,
    output logic              pc_stall,
    output logic              bubble,
    output logic [FW-1:0]     fwd_rs,
    output logic [FW-1:0]     fwd_rt
);
    localparam logic [FW-1:0] W_LAST = FW'(PIPE_DEPTH - 1);
    logic [PIPE_DEPTH-1:0] r_v, r_wr, r_ld, r_st;
    logic [REG_AW-1:0]     r_rd   [PIPE_DEPTH];
    logic [MEM_AW-1:0]     r_addr [PIPE_DEPTH];
    logic [2:0]            r_cnt;
    logic [FW-1:0]         w_ws, w_wt;
    logic                  w_mem, w_raw, w_hz, w_cti, w_bub, w_load;
    always_comb begin
        // scan oldest to youngest so the youngest match overwrites; value is k+1, 0 = none
        w_ws  = '0;
        w_wt  = '0;
        w_mem = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (id_rs_use && r_v[k] && r_wr[k] && r_rd[k] == id_rs && !(R0_ZERO != 0 && id_rs == '0))
                w_ws = FW'(k + 1);
            if (id_rt_use && r_v[k] && r_wr[k] && r_rd[k] == id_rt && !(R0_ZERO != 0 && id_rt == '0))
                w_wt = FW'(k + 1);
            if (MEM_CHECK != 0 && k <= 1 && (id_is_load || id_is_store) && r_v[k] && r_st[k] && r_addr[k] == id_mem_addr)
                w_mem = 1'b1;
        end
        // a match in the last slot never stalls: the register file writes through
        w_raw  = (FWD_EN != 0) ? (r_ld[0] && (w_ws == FW'(1) || w_wt == FW'(1)))
                               : ((w_ws != '0 && w_ws <= W_LAST) || (w_wt != '0 && w_wt <= W_LAST));
        w_hz   = id_valid && (w_raw || w_mem);
        // a cti arriving during the penalty window is itself bubbled, so it is never accepted
        w_cti  = id_valid && id_cti && !w_raw && !w_mem && r_cnt == '0;
        w_bub  = w_hz || r_cnt != '0;
        w_load = id_valid && !w_bub;
        pc_stall = rst && (w_hz || w_cti || r_cnt > 3'd1);
        bubble   = rst && w_bub;
        fwd_rs   = (FWD_EN != 0 && rst && id_valid && w_ws <= W_LAST) ? w_ws : '0;
        fwd_rt   = (FWD_EN != 0 && rst && id_valid && w_wt <= W_LAST) ? w_wt : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v   <= '0;
            r_wr  <= '0;
            r_ld  <= '0;
            r_st  <= '0;
            r_cnt <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_rd[k]   <= '0;
                r_addr[k] <= '0;
            end
        end else begin
            r_v   <= {r_v[PIPE_DEPTH-2:0], w_load};
            r_wr  <= {r_wr[PIPE_DEPTH-2:0], id_rd_wr};
            r_ld  <= {r_ld[PIPE_DEPTH-2:0], id_is_load};
            r_st  <= {r_st[PIPE_DEPTH-2:0], id_is_store};
            r_rd[0]   <= id_rd;
            r_addr[0] <= id_mem_addr;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_rd[k]   <= r_rd[k-1];
                r_addr[k] <= r_addr[k-1];
            end
            r_cnt <= w_cti ? 3'(BR_PENALTY) : (r_cnt != '0 ? r_cnt - 3'd1 : r_cnt);
        end
    end
endmodule
